// File: rtl/sram_pkg.sv
// Shared definitions for the dual-port SRAM behavioural model.
//   init_state_e    : clear/ready state encoding of the post-reset init FSM
//   CollCntWidth    : width of the saturating collision counter
//   MinReadLatency,
//   MaxReadLatency  : legal range of the read pipeline depth
//   latency_legal() : range check used to sanitise the latency parameter
package sram_pkg;

    typedef enum logic {
        StClear = 1'b0,
        StReady = 1'b1
    } init_state_e;

    localparam int unsigned CollCntWidth   = 16;
    localparam int unsigned MinReadLatency = 1;
    localparam int unsigned MaxReadLatency = 2;

    function automatic bit latency_legal(input int unsigned lat);
        return (lat >= MinReadLatency) && (lat <= MaxReadLatency);
    endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-data pipeline for one SRAM port.
//   clk, rst_n : clock, asynchronous active-low reset
//   req_valid  : a read was accepted on this edge
//   req_data   : read word for that request (already merged / fault-injected)
//   dout       : registered read data; holds its value when no read completes
// Latency 1 registers req_data straight into dout; latency 2 adds one
// valid-qualified stage in front of it.
module sram_rd_pipe
    import sram_pkg::*;
#(
    parameter int unsigned P_DATA_WIDTH   = 32,
    parameter int unsigned P_READ_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    input  logic [P_DATA_WIDTH-1:0] req_data,
    output logic [P_DATA_WIDTH-1:0] dout
);

    logic [P_DATA_WIDTH-1:0] dout_q;

    assign dout = dout_q;

    if (P_READ_LATENCY >= MaxReadLatency) begin : g_two_stage
        logic                    stage_valid_q;
        logic [P_DATA_WIDTH-1:0] stage_data_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stage_valid_q <= 1'b0;
                stage_data_q  <= '0;
                dout_q        <= '0;
            end else begin
                stage_valid_q <= req_valid;
                if (req_valid) begin
                    stage_data_q <= req_data;
                end
                if (stage_valid_q) begin
                    dout_q <= stage_data_q;
                end
            end
        end
    end else begin : g_one_stage
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dout_q <= '0;
            end else if (req_valid) begin
                dout_q <= req_data;
            end
        end
    end

endmodule

// File: rtl/sram_2p_bm_behavioral.sv
// Behavioural true dual-port SRAM with per-bit write mask.
//   clk, rst_n            : shared clock, asynchronous active-low reset
//   a_*/b_* men,wen,ren   : port memory/write/read enables
//   a_*/b_* addr,din,bm   : address, write data, bit mask (1 = bit written)
//   a_dout, b_dout        : registered read data, latency 1 or 2
//   init_busy             : high while the post-reset clear sweeps the array
//   coll_flag             : one-cycle pulse after a same-address collision
//   coll_cnt              : saturating collision count
module sram_2p_bm_behavioral
    import sram_pkg::*;
#(
    parameter int unsigned              P_DATA_WIDTH     = 32,
    parameter int unsigned              P_ADDR_WIDTH     = 8,
    parameter int unsigned              P_ADDR_COUNT     = 2 ** P_ADDR_WIDTH,
    parameter int unsigned              P_READ_LATENCY   = 1,
    parameter bit                       P_CLEAR_ON_RESET = 1'b1,
    parameter bit                       P_FORCE_ERROR    = 1'b0,
    parameter int unsigned              P_ERROR_ADDR     = 0,
    parameter logic [P_DATA_WIDTH-1:0]  P_ERROR_PATTERN  = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    a_men,
    input  logic                    a_wen,
    input  logic                    a_ren,
    input  logic [P_ADDR_WIDTH-1:0] a_addr,
    input  logic [P_DATA_WIDTH-1:0] a_din,
    input  logic [P_DATA_WIDTH-1:0] a_bm,
    output logic [P_DATA_WIDTH-1:0] a_dout,
    input  logic                    b_men,
    input  logic                    b_wen,
    input  logic                    b_ren,
    input  logic [P_ADDR_WIDTH-1:0] b_addr,
    input  logic [P_DATA_WIDTH-1:0] b_din,
    input  logic [P_DATA_WIDTH-1:0] b_bm,
    output logic [P_DATA_WIDTH-1:0] b_dout,
    output logic                    init_busy,
    output logic                    coll_flag,
    output logic [CollCntWidth-1:0] coll_cnt
);

    // Illegal latency values fall back to the minimum.
    localparam int unsigned Latency =
        latency_legal(P_READ_LATENCY) ? P_READ_LATENCY : MinReadLatency;

    typedef logic [P_DATA_WIDTH-1:0] word_t;

    function automatic word_t merge(input word_t old_w, input word_t din, input word_t bm);
        return (old_w & ~bm) | (din & bm);
    endfunction

    word_t mem [P_ADDR_COUNT];

    init_state_e             state_q, state_d;
    logic [P_ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                    coll_flag_q;
    logic [CollCntWidth-1:0] coll_cnt_q;

    logic  ready;
    logic  a_in_range, b_in_range, same_addr;
    logic  a_wr, b_wr, a_rd, b_rd, collision;
    word_t a_old, b_old, a_new, b_new, b_final;
    word_t a_rd_data, b_rd_data;

    assign ready      = (state_q == StReady);
    assign a_in_range = 32'(a_addr) < P_ADDR_COUNT;
    assign b_in_range = 32'(b_addr) < P_ADDR_COUNT;
    assign same_addr  = (a_addr == b_addr);

    assign a_wr = ready & a_men & a_wen & a_in_range;
    assign b_wr = ready & b_men & b_wen & b_in_range;
    assign a_rd = ready & a_men & a_ren;
    assign b_rd = ready & b_men & b_ren;

    assign collision = ready & a_men & b_men & same_addr & a_in_range & (a_wen | b_wen);

    assign a_old = a_in_range ? mem[a_addr] : '0;
    assign b_old = b_in_range ? mem[b_addr] : '0;

    // On a write/write collision B is merged first and A on top, so A wins
    // on overlapping mask bits; a_new is then the word that lands in the array.
    assign b_new   = merge(b_old, b_din, b_bm);
    assign a_new   = merge((b_wr && same_addr) ? b_new : a_old, a_din, a_bm);
    assign b_final = (a_wr && same_addr) ? a_new : b_new;

    // Write-through returns the stored word; a plain read sees pre-edge data.
    always_comb begin
        a_rd_data = '0;
        if (a_in_range) begin
            a_rd_data = a_wen ? a_new : a_old;
            if (P_FORCE_ERROR && (32'(a_addr) == P_ERROR_ADDR)) begin
                a_rd_data = a_rd_data ^ P_ERROR_PATTERN;
            end
        end
    end

    always_comb begin
        b_rd_data = '0;
        if (b_in_range) begin
            b_rd_data = b_wen ? b_final : b_old;
            if (P_FORCE_ERROR && (32'(b_addr) == P_ERROR_ADDR)) begin
                b_rd_data = b_rd_data ^ P_ERROR_PATTERN;
            end
        end
    end

    // Array has no reset: it is only ever touched on clock edges.
    always_ff @(posedge clk) begin
        if (state_q == StClear) begin
            mem[ptr_q] <= '0;
        end else begin
            if (b_wr) begin
                mem[b_addr] <= b_new;
            end
            if (a_wr) begin
                mem[a_addr] <= a_new;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            StClear: begin
                ptr_d = ptr_q + 1'b1;
                if (32'(ptr_q) == P_ADDR_COUNT - 1) begin
                    state_d = StReady;
                    ptr_d   = '0;
                end
            end
            StReady: begin
                state_d = StReady;
            end
            default: begin
                state_d = StReady;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= P_CLEAR_ON_RESET ? StClear : StReady;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll_flag_q <= 1'b0;
            coll_cnt_q  <= '0;
        end else begin
            coll_flag_q <= collision;
            if (collision && (coll_cnt_q != '1)) begin
                coll_cnt_q <= coll_cnt_q + 1'b1;
            end
        end
    end

    assign init_busy = (state_q == StClear);
    assign coll_flag = coll_flag_q;
    assign coll_cnt  = coll_cnt_q;

    sram_rd_pipe #(
        .P_DATA_WIDTH   (P_DATA_WIDTH),
        .P_READ_LATENCY (Latency)
    ) u_rd_pipe_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (a_rd),
        .req_data  (a_rd_data),
        .dout      (a_dout)
    );

    sram_rd_pipe #(
        .P_DATA_WIDTH   (P_DATA_WIDTH),
        .P_READ_LATENCY (Latency)
    ) u_rd_pipe_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (b_rd),
        .req_data  (b_rd_data),
        .dout      (b_dout)
    );

endmodule
